uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 108 ++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity_mode encodings and transmitter FSM state type
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side handshake and FIFO status of the UART transmitter
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    modport master (output wr_en, wr_data, input full, fifo_count, overflow);
    modport slave  (input wr_en, wr_data, output full, fifo_count, overflow);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data and registered flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      nxt;
    logic             wr, rd;
    assign wr      = wr_en && !full;
    assign rd      = rd_en && !empty;
    assign nxt     = count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    assign rd_data = mem[rp];
    always_ff @(posedge clk) begin
        if (wr && !rst)
            mem[wp] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr)
                wp <= wp + 1'b1;
            if (rd)
                rp <= rp + 1'b1;
            count <= nxt;
            full  <= nxt == FULL_CNT;
            empty <= nxt == '0;
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter; frame settings are latched per frame at pop time
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    uart_tx_fifo_if.slave    wif,
    output logic             busy,
    output logic             txd
);
    localparam logic [7:0] MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
    state_e           state;
    logic [DIV_W-1:0] cnt, div_l;
    logic [7:0]       shreg, rd_data;
    logic [2:0]       bit_idx;
    logic             par_en, par_bit, two_l, second, empty, pop, last_tick;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wif.wr_en),
        .wr_data (wif.wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (wif.full),
        .empty   (empty),
        .count   (wif.fifo_count)
    );
    assign last_tick = cnt == div_l;
    // popping in the final stop cycle chains frames with no idle gap
    assign pop = !empty && (state == IDLE || (state == STOP && last_tick && (!two_l || second)));
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            txd          <= 1'b1;
            busy         <= 1'b0;
            cnt          <= '0;
            div_l        <= '0;
            shreg        <= '0;
            bit_idx      <= '0;
            par_en       <= 1'b0;
            par_bit      <= 1'b0;
            two_l        <= 1'b0;
            second       <= 1'b0;
            wif.overflow <= 1'b0;
        end else begin
            if (wif.wr_en && wif.full)
                wif.overflow <= 1'b1;
            if (pop) begin
                state   <= START;
                txd     <= 1'b0;
                busy    <= 1'b1;
                cnt     <= '0;
                div_l   <= (div == '0) ? DIV_W'(1) : div;
                shreg   <= rd_data;
                bit_idx <= '0;
                par_en  <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
                par_bit <= (^(rd_data & MASK)) ^ (parity_mode == PAR_ODD);
                two_l   <= two_stop;
                second  <= 1'b0;
            end else if (state != IDLE) begin
                if (!last_tick) begin
                    cnt <= cnt + DIV_W'(1);
                end else begin
                    cnt <= '0;
                    case (state)
                        START: begin
                            state <= DATA;
                            txd   <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                        DATA: begin
                            if (bit_idx == LAST) begin
                                state <= par_en ? PARITY : STOP;
                                txd   <= par_en ? par_bit : 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                txd     <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end
                        STOP: begin
                            if (two_l && !second) begin
                                second <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                txd   <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: per-cycle waveform model of the 8-bit instance plus directed literal checks
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd3;
    logic [1:0]  pm = 2'b00;
    logic        two = 1'b0;
    logic        a_busy, a_txd, b_busy, b_txd;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        cap [0:1023];
    int          lat, len;

    uart_tx_fifo_if #(.FIFO_DEPTH(16)) a_if ();
    uart_tx_fifo_if #(.FIFO_DEPTH(16)) b_if ();

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16)) dut_a (
        .clk(clk), .rst(rst), .div(div), .parity_mode(pm), .two_stop(two),
        .wif(a_if), .busy(a_busy), .txd(a_txd)
    );
    uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(16), .DIV_W(16)) dut_b (
        .clk(clk), .rst(rst), .div(div), .parity_mode(pm), .two_stop(two),
        .wif(b_if), .busy(b_busy), .txd(b_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // waveform model: each accepted byte becomes a queue of expected per-cycle txd values
    logic [7:0] mq [$];
    logic       mexp [$];
    logic       movf = 1'b0;
    logic       m_pop, m_wok;
    logic [7:0] mb;
    logic       fb [12];
    int         nb, per;

    always @(negedge clk) begin
        chk("m_txd", 32'(a_txd), (mexp.size() != 0) ? 32'(mexp[0]) : 32'd1);
        chk("m_busy", 32'(a_busy), 32'(mexp.size() != 0));
        chk("m_count", 32'(a_if.fifo_count), mq.size());
        chk("m_full", 32'(a_if.full), 32'(mq.size() == 16));
        chk("m_overflow", 32'(a_if.overflow), 32'(movf));
        if (rst) begin
            mq.delete();
            mexp.delete();
            movf = 1'b0;
        end else begin
            m_pop = mq.size() != 0 && mexp.size() <= 1;
            m_wok = a_if.wr_en && mq.size() < 16;
            if (a_if.wr_en && mq.size() == 16)
                movf = 1'b1;
            if (mexp.size() != 0)
                void'(mexp.pop_front());
            if (m_pop) begin
                mb = mq.pop_front();
                per = (div == 0) ? 2 : int'(div) + 1;
                fb[0] = 1'b0;
                nb = 1;
                for (int k = 0; k < 8; k++) begin
                    fb[nb] = mb[k];
                    nb++;
                end
                if (pm == 2'b01 || pm == 2'b10) begin
                    fb[nb] = (^mb) ^ (pm == 2'b10);
                    nb++;
                end
                fb[nb] = 1'b1;
                nb++;
                if (two) begin
                    fb[nb] = 1'b1;
                    nb++;
                end
                for (int j = 0; j < nb; j++)
                    repeat (per) mexp.push_back(fb[j]);
            end
            if (m_wok)
                mq.push_back(a_if.wr_data);
        end
    end

    function automatic logic bz(input logic sel);
        return sel ? b_busy : a_busy;
    endfunction

    task automatic put(input logic sel, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (sel) begin b_if.wr_en = 1'b1; b_if.wr_data = d; end
        else begin a_if.wr_en = 1'b1; a_if.wr_data = d; end
        @(posedge clk);
        #1;
        a_if.wr_en = 1'b0;
        b_if.wr_en = 1'b0;
    endtask

    task automatic capture(input logic sel);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bz(sel) && lat < 200);
        chk("busy_timeout", 32'(lat < 200), 32'd1);
        len = 0;
        while (bz(sel) && len < 1024) begin
            cap[len] = sel ? b_txd : a_txd;
            len++;
            @(negedge clk);
        end
        chk("frame_timeout", 32'(len < 1024), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e55;
        int ones, act;
        e55 = 10'b1010101010;
        a_if.wr_en = 1'b0; a_if.wr_data = '0;
        b_if.wr_en = 1'b0; b_if.wr_data = '0;
        @(negedge clk);
        chk("rst_txd", 32'(a_txd), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_count", 32'(a_if.fifo_count), 32'd0);
        chk("rst_full", 32'(a_if.full), 32'd0);
        chk("rst_ovf", 32'(a_if.overflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        put(1'b0, 8'h55);
        capture(1'b0);
        chk("lat_55", lat, 32'd2);
        chk("len_55", len, 32'd40);
        for (int i = 0; i < 10; i++)
            chk("bit_55", 32'(cap[4*i+2]), 32'(e55[i]));

        pm = 2'b01;
        put(1'b0, 8'h07);
        capture(1'b0);
        chk("len_even", len, 32'd44);
        chk("par_even", 32'(cap[38]), 32'd1);
        pm = 2'b10;
        put(1'b0, 8'h07);
        capture(1'b0);
        chk("par_odd", 32'(cap[38]), 32'd0);
        pm = 2'b11;
        put(1'b0, 8'h07);
        capture(1'b0);
        chk("len_pm11", len, 32'd40);
        pm = 2'b00;
        two = 1'b1;
        put(1'b0, 8'h07);
        capture(1'b0);
        chk("len_two", len, 32'd44);
        ones = 0;
        for (int i = 36; i < 44; i++)
            ones += int'(cap[i]);
        chk("stop_two", ones, 32'd8);
        chk("last_data_two", 32'(cap[35]), 32'd0);
        two = 1'b0;

        div = 16'd0;
        put(1'b0, 8'h01);
        capture(1'b0);
        chk("len_div0", len, 32'd20);
        div = 16'd3;

        fork
            capture(1'b0);
            begin
                put(1'b0, 8'h0F);
                put(1'b0, 8'hF0);
                repeat (10) @(posedge clk);
                #1 div = 16'd7;
            end
        join
        chk("len_divchg", len, 32'd120);
        chk("f1_bit3", 32'(cap[18]), 32'd1);
        chk("f1_bit4", 32'(cap[22]), 32'd0);
        chk("f1_stop", 32'(cap[39]), 32'd1);
        chk("f2_start", 32'(cap[44]), 32'd0);
        chk("f2_bit0", 32'(cap[52]), 32'd0);
        chk("f2_bit4", 32'(cap[84]), 32'd1);
        div = 16'd3;

        @(posedge clk);
        #1 a_if.wr_en = 1'b1;
        a_if.wr_data = 8'd1;
        fork
            capture(1'b0);
            begin
                for (int i = 2; i <= 18; i++) begin
                    @(posedge clk);
                    #1 a_if.wr_data = 8'(i);
                end
                @(posedge clk);
                #1 a_if.wr_en = 1'b0;
                @(negedge clk);
                chk("burst_count", 32'(a_if.fifo_count), 32'd16);
                chk("burst_full", 32'(a_if.full), 32'd1);
                chk("burst_ovf", 32'(a_if.overflow), 32'd1);
            end
        join
        chk("burst_len", len, 32'd680);
        for (int f = 0; f < 17; f++) begin
            chk("burst_start", 32'(cap[40*f+2]), 32'd0);
            for (int k = 0; k < 8; k++)
                chk("burst_bit", 32'(cap[40*f+4*(k+1)+2]), 32'(((f + 1) >> k) & 1));
        end
        chk("burst_drain", 32'(a_if.fifo_count), 32'd0);

        @(posedge clk);
        #1 a_if.wr_en = 1'b1;
        a_if.wr_data = 8'hA0;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1 a_if.wr_data = 8'hA0 + 8'(i);
        end
        @(posedge clk);
        #1 a_if.wr_en = 1'b0;
        @(negedge clk);
        chk("queued5", 32'(a_if.fifo_count), 32'd5);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        a_if.wr_en = 1'b1;
        a_if.wr_data = 8'h33;
        @(posedge clk);
        #1 rst = 1'b0;
        a_if.wr_en = 1'b0;
        @(negedge clk);
        chk("midrst_txd", 32'(a_txd), 32'd1);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_count", 32'(a_if.fifo_count), 32'd0);
        chk("midrst_ovf", 32'(a_if.overflow), 32'd0);
        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_busy || !a_txd)
                act++;
        end
        chk("midrst_quiet", act, 32'd0);

        put(1'b1, 8'hFF);
        capture(1'b1);
        chk("b_lat", lat, 32'd2);
        chk("b_len", len, 32'd28);
        for (int i = 0; i < 7; i++)
            chk("b_bit", 32'(cap[4*i+2]), (i == 0) ? 32'd0 : 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
